// File: rtl/trace_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : trace_event_monitor
// Purpose  : Watches the retired-instruction trace for l.nop K event markers
//            and queues exit/report/putc events for an external consumer.
// Revision : 1.0 - initial release
// ============================================================================
module trace_event_monitor #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trace_enable,
    input  logic [31:0] trace_insn,
    input  logic        trace_wben,
    input  logic [4:0]  trace_wbreg,
    input  logic [31:0] trace_wbdata,
    output logic        evt_valid,
    output logic [1:0]  evt_type,
    output logic [31:0] evt_data,
    input  logic        evt_ready,
    output logic        terminated,
    output logic        overflow,
    output logic [31:0] r3
);

    localparam int          c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          c_CNT_W  = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [1:0]  c_EVT_EXIT   = 2'd0;
    localparam logic [1:0]  c_EVT_REPORT = 2'd1;
    localparam logic [1:0]  c_EVT_PUTC   = 2'd2;

    logic [1:0]         r_type_mem [FIFO_DEPTH];
    logic [31:0]        r_data_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [31:0]        r_r3;
    logic               r_terminated;
    logic               r_overflow;

    logic               w_is_nop;
    logic               w_evt_hit;
    logic [1:0]         w_evt_type;
    logic [31:0]        w_evt_data;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_exit;
    logic [c_CNT_W-1:0] w_count_next;

    // Once terminated, event beats are no longer decoded at all.
    assign w_is_nop = trace_enable && (trace_insn[31:16] == 16'h1500) && !r_terminated;

    always_comb begin
        w_evt_hit  = 1'b0;
        w_evt_type = c_EVT_EXIT;
        w_evt_data = r_r3;
        case (trace_insn[15:0])
            16'h0001: begin
                w_evt_hit  = w_is_nop;
                w_evt_type = c_EVT_EXIT;
            end
            16'h0002: begin
                w_evt_hit  = w_is_nop;
                w_evt_type = c_EVT_REPORT;
            end
            16'h0004: begin
                w_evt_hit  = w_is_nop;
                w_evt_type = c_EVT_PUTC;
                w_evt_data = {24'h0, r_r3[7:0]};
            end
            default: w_evt_hit = 1'b0;
        endcase
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_pop   = !w_empty && evt_ready;
    assign w_push  = w_evt_hit && (!w_full || w_pop);
    assign w_drop  = w_evt_hit && w_full && !w_pop;
    assign w_exit  = w_evt_hit && (w_evt_type == c_EVT_EXIT);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_r3         <= '0;
            r_terminated <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            // Payloads above were taken from the pre-writeback r3 value.
            if (trace_enable && trace_wben && (trace_wbreg == 5'd3)) begin
                r_r3 <= trace_wbdata;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_exit) begin
                r_terminated <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_type_mem[r_wr_ptr] <= w_evt_type;
            r_data_mem[r_wr_ptr] <= w_evt_data;
        end
    end

    assign evt_valid  = !w_empty;
    assign evt_type   = w_empty ? 2'd0  : r_type_mem[r_rd_ptr];
    assign evt_data   = w_empty ? 32'd0 : r_data_mem[r_rd_ptr];
    assign terminated = r_terminated;
    assign overflow   = r_overflow;
    assign r3         = r_r3;

endmodule
`default_nettype wire

// File: tb/tb_trace_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_event_monitor
// Purpose  : Self-checking bench for trace_event_monitor: vector table,
//            randomized traffic against a queue model, and corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trace_event_monitor;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_enable;
    logic [31:0] trace_insn;
    logic        trace_wben;
    logic [4:0]  trace_wbreg;
    logic [31:0] trace_wbdata;
    logic        evt_valid;
    logic [1:0]  evt_type;
    logic [31:0] evt_data;
    logic        evt_ready;
    logic        terminated;
    logic        overflow;
    logic [31:0] r3;

    trace_event_monitor #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .trace_enable (trace_enable),
        .trace_insn   (trace_insn),
        .trace_wben   (trace_wben),
        .trace_wbreg  (trace_wbreg),
        .trace_wbdata (trace_wbdata),
        .evt_valid    (evt_valid),
        .evt_type     (evt_type),
        .evt_data     (evt_data),
        .evt_ready    (evt_ready),
        .terminated   (terminated),
        .overflow     (overflow),
        .r3           (r3)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]  t;
        logic [31:0] d;
    } evt_t;

    evt_t        m_q[$];
    logic [31:0] m_r3;
    logic        m_term;
    logic        m_ovf;

    typedef struct {
        logic        rst;
        logic        en;
        logic [31:0] insn;
        logic        wben;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
        logic        ready;
        logic        exp_valid;
        logic [1:0]  exp_type;
        logic [31:0] exp_data;
        logic        exp_term;
        logic        exp_ovf;
        logic [31:0] exp_r3;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: events are decoded from the specification's rules
    // and held in a plain queue bounded by DEPTH.
    task automatic model_update();
        evt_t e;
        bit   hit;
        bit   pop;
        if (rst) begin
            m_q.delete();
            m_r3   = 32'h0;
            m_term = 1'b0;
            m_ovf  = 1'b0;
            return;
        end
        pop = (m_q.size() > 0) && evt_ready;
        hit = 1'b0;
        e.t = 2'd0;
        e.d = m_r3;
        if (trace_enable && trace_insn[31:16] == 16'h1500 && !m_term) begin
            if (trace_insn[15:0] == 16'h0001) begin hit = 1; e.t = 2'd0; e.d = m_r3; end
            if (trace_insn[15:0] == 16'h0002) begin hit = 1; e.t = 2'd1; e.d = m_r3; end
            if (trace_insn[15:0] == 16'h0004) begin hit = 1; e.t = 2'd2; e.d = m_r3 & 32'hFF; end
        end
        if (pop) void'(m_q.pop_front());
        if (hit) begin
            if (m_q.size() < DEPTH) m_q.push_back(e);
            else m_ovf = 1'b1;
            if (e.t == 2'd0) m_term = 1'b1;
        end
        if (trace_enable && trace_wben && trace_wbreg == 5'd3) m_r3 = trace_wbdata;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, 32'(evt_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk({tag, ".type"}, 32'(evt_type), 32'(m_q[0].t));
            chk({tag, ".data"}, evt_data, m_q[0].d);
        end
        chk({tag, ".term"}, 32'(terminated), 32'(m_term));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".r3"}, r3, m_r3);
    endtask

    task automatic step(input logic r, input logic en, input logic [31:0] insn,
                        input logic wb, input logic [4:0] reg_i,
                        input logic [31:0] wdata, input logic rdy);
        rst          = r;
        trace_enable = en;
        trace_insn   = insn;
        trace_wben   = wb;
        trace_wbreg  = reg_i;
        trace_wbdata = wdata;
        evt_ready    = rdy;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, rdy);
    endtask

    task automatic putc_beat(input logic [31:0] next_r3, input logic rdy);
        step(1'b0, 1'b1, 32'h15000004, 1'b1, 5'd3, next_r3, rdy);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; trace_enable = 0; trace_insn = 0; trace_wben = 0;
        trace_wbreg = 0; trace_wbdata = 0; evt_ready = 0;
        m_r3 = 0; m_term = 0; m_ovf = 0;

        //          rst en insn          wb reg  wbdata        rdy  v  ty  data          tm ov r3
        tbl[0]  = '{1, 0, 32'h0,        0, 0, 32'h0,        0,  0, 0, 32'h0,        0, 0, 32'h0};
        tbl[1]  = '{0, 1, 32'h0,        1, 3, 32'h41,       0,  0, 0, 32'h0,        0, 0, 32'h41};
        tbl[2]  = '{0, 1, 32'h15000004, 0, 0, 32'h0,        0,  1, 2, 32'h41,       0, 0, 32'h41};
        tbl[3]  = '{0, 0, 32'h0,        0, 0, 32'h0,        1,  0, 0, 32'h0,        0, 0, 32'h41};
        tbl[4]  = '{0, 1, 32'h0,        1, 3, 32'h5,        0,  0, 0, 32'h0,        0, 0, 32'h5};
        tbl[5]  = '{0, 1, 32'h15000002, 1, 3, 32'h7,        0,  1, 1, 32'h5,        0, 0, 32'h7};
        tbl[6]  = '{0, 1, 32'h15000003, 0, 0, 32'h0,        0,  1, 1, 32'h5,        0, 0, 32'h7};
        tbl[7]  = '{0, 1, 32'h15000004, 1, 4, 32'h99,       1,  1, 2, 32'h7,        0, 0, 32'h7};
        tbl[8]  = '{0, 0, 32'h0,        0, 0, 32'h0,        1,  0, 0, 32'h0,        0, 0, 32'h7};
        tbl[9]  = '{0, 1, 32'h15010004, 0, 0, 32'h0,        0,  0, 0, 32'h0,        0, 0, 32'h7};
        tbl[10] = '{0, 0, 32'h15000004, 0, 0, 32'h0,        0,  0, 0, 32'h0,        0, 0, 32'h7};
        tbl[11] = '{0, 1, 32'h0,        1, 3, 32'h12345678, 0,  0, 0, 32'h0,        0, 0, 32'h12345678};
        tbl[12] = '{0, 1, 32'h15000004, 0, 0, 32'h0,        0,  1, 2, 32'h78,       0, 0, 32'h12345678};
        tbl[13] = '{1, 1, 32'h15000001, 1, 3, 32'h5,        0,  0, 0, 32'h0,        0, 0, 32'h0};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].insn, tbl[i].wben, tbl[i].wbreg,
                 tbl[i].wbdata, tbl[i].ready);
            chk($sformatf("vec%0d.valid", i), 32'(evt_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid || tbl[i].rst) begin
                chk($sformatf("vec%0d.type", i), 32'(evt_type), 32'(tbl[i].exp_type));
                chk($sformatf("vec%0d.data", i), evt_data, tbl[i].exp_data);
            end
            chk($sformatf("vec%0d.term", i), 32'(terminated), 32'(tbl[i].exp_term));
            chk($sformatf("vec%0d.ovf", i), 32'(overflow), 32'(tbl[i].exp_ovf));
            chk($sformatf("vec%0d.r3", i), r3, tbl[i].exp_r3);
        end

        // Randomized traffic against the queue model.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] insn;
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 2)       insn = 32'h15000001;
            else if (sel < 30) insn = 32'h15000002;
            else if (sel < 60) insn = 32'h15000004;
            else if (sel < 70) insn = 32'h15000000 | $urandom_range(0, 15);
            else               insn = $urandom;
            step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0), insn,
                 1'($urandom), ($urandom_range(0, 1) != 0) ? 5'd3 : 5'($urandom),
                 $urandom, 1'($urandom_range(0, 2) != 0));
            check_model("rand");
        end

        // Five putc beats into a 4-deep queue with no consumer.
        step(1'b1, 0, 0, 0, 0, 0, 0);
        step(1'b0, 1, 32'h0, 1, 3, 32'h10, 0);
        for (int i = 0; i < 5; i++) putc_beat(32'h11 + i, 0);
        chk("ovf_after_fifth", 32'(overflow), 32'h1);
        check_model("ovf");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d.data", i), evt_data, 32'h10 + i);
            idle(1'b1);
        end
        chk("drain_empty", 32'(evt_valid), 32'h0);

        // Full queue with simultaneous push and pop.
        step(1'b1, 0, 0, 0, 0, 0, 0);
        step(1'b0, 1, 32'h0, 1, 3, 32'h20, 0);
        for (int i = 0; i < 4; i++) putc_beat(32'h21 + i, 0);
        putc_beat(32'h25, 1);
        chk("fullpop.ovf", 32'(overflow), 32'h0);
        check_model("fullpop");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fullpop%0d.data", i), evt_data, 32'h21 + i);
            idle(1'b1);
        end
        chk("fullpop_empty", 32'(evt_valid), 32'h0);

        // Exit event blocks later events.
        step(1'b1, 0, 0, 0, 0, 0, 0);
        step(1'b0, 1, 32'h0, 1, 3, 32'hDEAD, 0);
        step(1'b0, 1, 32'h15000001, 0, 0, 0, 0);
        putc_beat(32'h55, 0);
        chk("exit.type", 32'(evt_type), 32'h0);
        chk("exit.data", evt_data, 32'hDEAD);
        chk("exit.term", 32'(terminated), 32'h1);
        chk("exit.r3", r3, 32'h55);
        idle(1'b1);
        chk("exit.no_putc", 32'(evt_valid), 32'h0);
        check_model("exit");

        // Reset with three events queued.
        step(1'b1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) putc_beat(32'h30 + i, 0);
        step(1'b0, 1, 32'h15000001, 0, 0, 0, 0);
        step(1'b1, 0, 0, 0, 0, 0, 0);
        chk("rst.valid", 32'(evt_valid), 32'h0);
        chk("rst.term", 32'(terminated), 32'h0);
        chk("rst.ovf", 32'(overflow), 32'h0);
        chk("rst.r3", r3, 32'h0);
        idle(1'b1);
        chk("rst.stay_empty", 32'(evt_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
